// File: rtl/dly_pkg.sv
// Shared constants and types for the delay-chain output buffer.
package dly_pkg;

  localparam int unsigned DLY_WIDTH = 3;
  localparam int unsigned DLY_DEPTH = 8;

  typedef logic [DLY_WIDTH-1:0]       dly_word_t;
  typedef logic [$clog2(DLY_DEPTH):0] dly_level_t;

endpackage

// File: rtl/dly_fifo_mem.sv
// Storage array for dly_fifo: one synchronous write port, one asynchronous read port.
module dly_fifo_mem #(
  parameter int unsigned  WIDTH = 3,
  parameter int unsigned  DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dly_fifo.sv
// Elastic valid/ready buffer behind the delay chain; show-ahead circular FIFO.
// Optional sticky overflow flag enabled by defining DLY_FIFO_OVF_EN.
module dly_fifo
  import dly_pkg::*;
#(
  parameter int unsigned  WIDTH = DLY_WIDTH,
  parameter int unsigned  DEPTH = DLY_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic             full,
  output logic             ovf
);

  localparam logic [AW:0]   LvlFull = DEPTH[AW:0];
  localparam logic [AW:0]   LvlOne  = 1;
  localparam logic [AW-1:0] PtrOne  = 1;

  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      level_q, level_d;
  logic             push, pop;
  logic [WIDTH-1:0] rd_data;

  assign full      = (level_q == LvlFull);
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign pop       = out_valid & out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push      = in_valid & (~full | pop);

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlOne;
    end else if (pop && !push) begin
      level_d = level_q - LvlOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PtrOne;
      if (pop)  rp_q <= rp_q + PtrOne;
      level_q <= level_d;
    end
  end

  dly_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wp_q),
    .wdata (in_data),
    .raddr (rp_q),
    .rdata (rd_data)
  );

  // Gate the unreset memory so an empty FIFO presents zero.
  assign out_data = out_valid ? rd_data : '0;

`ifdef DLY_FIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (in_valid && full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dly_fifo.sv
// Directed self-checking bench for dly_fifo.
module tb_dly_fifo;
  import dly_pkg::*;

`ifdef DLY_FIFO_OVF_EN
  localparam bit OvfOn = 1'b1;
`else
  localparam bit OvfOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  dly_word_t  in_data;
  logic       out_valid;
  dly_word_t  out_data;
  logic       out_ready;
  dly_level_t level;
  logic       full;
  logic       ovf;

  int n_checks = 0;
  int n_fails  = 0;

  dly_fifo u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned exp_drain [8];
    dly_word_t   q [$];
    int          pushed;
    int          guard;
    logic        v, r;
    dly_word_t   d;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    step();

    // Streaming 3,5,7 with out_ready held high
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 3; step();
    check("stream_v0", out_valid, 1); check("stream_d0", out_data, 3); check("stream_l0", level, 1);
    in_data = 5; step();
    check("stream_d1", out_data, 5); check("stream_l1", level, 1);
    in_data = 7; step();
    check("stream_d2", out_data, 7); check("stream_l2", level, 1);
    in_valid = 1'b0; step();
    check("stream_empty", out_valid, 0); check("stream_l3", level, 0);

    // Fill with 0..7, then overflow attempt with 6
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = dly_word_t'(i); step();
      check("fill_level", level, i + 1);
    end
    check("fill_full", full, 1);
    check("fill_ovf_pre", ovf, 0);
    in_data = 6; step();
    check("ovf_level", level, 8);
    check("ovf_full", full, 1);
    check("ovf_flag", ovf, OvfOn);
    check("ovf_head", out_data, 0);

    // Full with simultaneous push (5) and pop
    in_data = 5; out_ready = 1'b1; step();
    check("pp_level", level, 8);
    check("pp_full", full, 1);
    check("pp_ovf", ovf, OvfOn);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) exp_drain[i] = i + 1;
    exp_drain[7] = 5;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, exp_drain[i]);
      step();
    end
    check("drain_empty", out_valid, 0);
    check("drain_level", level, 0);

    // Asynchronous reset with 5 words held
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = dly_word_t'(i + 2); step();
    end
    in_valid = 1'b0;
    check("pre_rst_level", level, 5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_level", level, 0);
    check("arst_ovf", ovf, 0);
    check("arst_full", full, 0);
    step();
    rst = 1'b0;
    step();

    // Random wrap-around, kept below full, against a queue model
    pushed = 0;
    guard = 0;
    while ((pushed < 20 || q.size() != 0) && guard < 200) begin
      guard++;
      check("wrap_valid", out_valid, (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) check("wrap_data", out_data, q[0]);
      v = (pushed < 20) && (q.size() < 7) && ($urandom_range(1, 0) == 1);
      r = ($urandom_range(1, 0) == 1) || (pushed >= 20);
      d = dly_word_t'($urandom_range(7, 0));
      in_valid = v; in_data = d; out_ready = r;
      step();
      if (r && q.size() != 0) void'(q.pop_front());
      if (v) begin
        q.push_back(d);
        pushed++;
      end
      check("wrap_level", level, q.size());
    end
    check("wrap_done", guard < 200, 1);
    in_valid = 1'b0; out_ready = 1'b0;

    // Stall hold: head stays put while pushes continue
    in_valid = 1'b1; in_data = 4; step();
    check("stall_head", out_data, 4);
    for (int i = 0; i < 4; i++) begin
      in_data = dly_word_t'(i); step();
      check("stall_data", out_data, 4);
      check("stall_valid", out_valid, 1);
      check("stall_level", level, i + 2);
    end
    in_valid = 1'b0;
    step();
    check("stall_final", level, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
